mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the word-wide data-memory port. Sits between the MEM stage and the data memory
//  and turns one request (LW/LH/LHU/LB/LBU/SW/SH/SB) into memory read/write cycles. Sub-word stores
//  use a two-cycle read-modify-write. Sub-word loads are lane-extracted and sign- or zero-extended.
// PARAMETERS
//  ADDR_W  32  width of Addr and MemAddress
//  DATA_W  32  data word width (fixed 32; byte lanes assume 4 bytes)
// PORTS
//  Clk          in   1   clock, rising edge
//  Reset        in   1   asynchronous, active-high reset
//  Req          in   1   request valid; accepted when Req && Ready
//  Op           in   3   operation code (mem_access_pkg)
//  Addr         in   32  byte address
//  StoreData    in   32  store source; SB/SH use low bits
//  Ready        out  1   controller idle, can accept a request
//  Done         out  1   one-cycle completion pulse
//  LoadData     out  32  extended load result, valid when Done
//  Misaligned   out  1   misaligned-access flag, valid when Done
//  MemAddress   out  32  to memory: {latched Addr[31:2],2'b00}
//  MemWriteData out  32  to memory: full or merged word
//  MemWrite     out  1   to memory: write strobe; memory writes on Clk rise
//  MemRead      out  1   to memory: read enable
//  MemReadData  in   32  from memory: combinational read data
// BEHAVIOUR
//  Reset (async): state=IDLE; Ready=1; Done=0; Misaligned=0; LoadData=0; MemRead=MemWrite=0; MemAddress=0; MemWriteData=0.
//  FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR. Ready=(state==IDLE).
//  MemRead=1 in LOAD and RMW_RD only. MemWrite=1 in STORE and RMW_WR only; both decoded from state.
//  On accept: Op, Addr and StoreData are latched. Next state: LW/LH/LHU/LB/LBU->LOAD, SW->STORE, SH/SB->RMW_RD.
//  LOAD: extracted result is registered into LoadData at end of cycle -> IDLE.
//  STORE: MemWriteData=StoreData -> IDLE.
//  RMW_RD: MemReadData is captured into a word register -> RMW_WR.
//  RMW_WR: MemWriteData=captured word with target lane(s) replaced -> IDLE.
//  Done is registered and asserted in the cycle after the last memory cycle (state is IDLE then).
//  Latency, accept edge to Done: loads and SW = 2 cycles; SH/SB = 3 cycles.
//  Back-to-back: a Req in the Done cycle is accepted (Ready=1), with no bubble.
//  Req while busy: ignored; requester holds Req/Op/Addr until Ready.
//  Lanes (little-endian): byte k=Addr[1:0] is bits [8k+7:8k]; halfword Addr[1] selects [31:16]/[15:0].
//  LB/LH sign-extend; LBU/LHU zero-extend. LoadData holds its value until the next load completes.
//  Reset mid-operation: immediate IDLE, MemWrite drops combinationally, no write, captured word discarded.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: word access with Addr[1:0]!=0, or half with Addr[0]=1, makes no memory
//   cycle; one idle cycle, then Done=1 with Misaligned=1 and LoadData=0 for loads; memory untouched.
//  Undefined: Addr[1:0] ignored for words and Addr[0] for halves (forced aligned); Misaligned tied 0.
// STRUCTURE
//  mem_access_pkg: Op encodings LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7; FSM state enum; lane-width constants.
//  Sub-module lane_align (combinational): load extract/extend and store merge; instantiated once.
// TESTING
//  1 Assert Reset mid-sim -> Ready=1, Done=0, MemRead=MemWrite=0, LoadData=0 with no clock edge.
//  2 SW 0xDEADBEEF@0x10, then LW@0x10 issued in the Done cycle -> MemWrite 1 cycle with MemAddress=0x10;
//    LW accepted without a bubble; LoadData=0xDEADBEEF 2 cycles later.
//  3 Mem[0x10]=0x11223344; SB 0x5A@0x13 -> MemRead 1 cycle, then MemWrite with 0x5A223344; Done 3 cycles after accept.
//  4 Mem[0x10]=0x80223344: LB@0x13->0xFFFFFF80; LBU@0x13->0x00000080; LH@0x12->0xFFFF8022; LHU@0x10->0x00003344.
//  5 SH 0xBEEF@0x20; Reset asserted during RMW_RD -> MemWrite never 1; Mem[0x20] unchanged; Ready=1.
//  6 LW@0x102: with MISALIGN_TRAP_EN -> no MemRead, Done=1 with Misaligned=1 and LoadData=0;
//    without -> MemAddress=0x100 and word loaded.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller: op encodings, FSM state codes,
// lane widths and small op-classification helpers.
package mem_access_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } memOp_e;

   // ST_TRAP is only reachable when misaligned-access trapping is compiled in
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STORE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   function automatic logic isLoadOp(input memOp_e op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
             (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic isMisaligned(input memOp_e op, input logic [1:0] offset);
      logic result;
      case (op)
         OP_LW, OP_SW:         result = (offset != 2'b00);
         OP_LH, OP_LHU, OP_SH: result = offset[0];
         default:              result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane logic: extracts and extends sub-word loads, and merges sub-word
// store data into a previously read word (little-endian lanes).
module lane_align
   import mem_access_pkg::*;
(
   input  memOp_e      op_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] loadWord_i,
   input  logic [31:0] mergeWord_i,
   input  logic [31:0] storeData_i,
   output logic [31:0] loadResult_o,
   output logic [31:0] mergedWord_o
);

   logic [BYTE_W-1:0] byteLane;
   logic [HALF_W-1:0] halfLane;

   // Halfword selection only looks at offset bit 1, so odd halfword offsets are forced aligned
   always_comb begin
      byteLane = loadWord_i[{offset_i, 3'b000} +: BYTE_W];
      halfLane = offset_i[1] ? loadWord_i[31:16] : loadWord_i[15:0];
      case (op_i)
         OP_LB:   loadResult_o = {{(WORD_W-BYTE_W){byteLane[BYTE_W-1]}}, byteLane};
         OP_LBU:  loadResult_o = {{(WORD_W-BYTE_W){1'b0}}, byteLane};
         OP_LH:   loadResult_o = {{(WORD_W-HALF_W){halfLane[HALF_W-1]}}, halfLane};
         OP_LHU:  loadResult_o = {{(WORD_W-HALF_W){1'b0}}, halfLane};
         default: loadResult_o = loadWord_i;
      endcase
   end

   always_comb begin
      mergedWord_o = mergeWord_i;
      case (op_i)
         OP_SB: mergedWord_o[{offset_i, 3'b000} +: BYTE_W] = storeData_i[BYTE_W-1:0];
         OP_SH: begin
            if (offset_i[1]) mergedWord_o[31:16] = storeData_i[HALF_W-1:0];
            else             mergedWord_o[15:0]  = storeData_i[HALF_W-1:0];
         end
         default: mergedWord_o = storeData_i;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the word-wide data-memory port; sub-word stores use read-modify-write.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing them aligned.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic [2:0]        Op,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] StoreData,
   output logic              Ready,
   output logic              Done,
   output logic [DATA_W-1:0] LoadData,
   output logic              Misaligned,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] MemWriteData,
   output logic              MemWrite,
   output logic              MemRead,
   input  logic [DATA_W-1:0] MemReadData
);

   logic [2:0]        state_q, state_d;
   memOp_e            op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] storeData_q;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] loadData_q, loadData_d;
   logic              done_q, done_d;
   logic              accept;
   memOp_e            reqOp;
   logic [31:0]       loadResult;
   logic [31:0]       mergedWord;

   assign reqOp  = memOp_e'(Op);
   assign accept = Req && (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (isLoadOp(reqOp))    state_d = ST_LOAD;
               else if (reqOp == OP_SW) state_d = ST_STORE;
               else                     state_d = ST_RMW_RD;
`ifdef MISALIGN_TRAP_EN
               if (isMisaligned(reqOp, Addr[1:0])) state_d = ST_TRAP;
`endif
            end
         end
         ST_RMW_RD: state_d = ST_RMW_WR;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Done follows the final memory cycle (or the trap's idle cycle) by one clock
   assign done_d = (state_q == ST_LOAD) || (state_q == ST_STORE) ||
                   (state_q == ST_RMW_WR) || (state_q == ST_TRAP);

   always_comb begin
      loadData_d = loadData_q;
      if (state_q == ST_LOAD) loadData_d = loadResult;
`ifdef MISALIGN_TRAP_EN
      if ((state_q == ST_TRAP) && isLoadOp(op_q)) loadData_d = '0;
`endif
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LW;
         addr_q      <= '0;
         storeData_q <= '0;
         word_q      <= '0;
         loadData_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         loadData_q <= loadData_d;
         if (accept) begin
            op_q        <= reqOp;
            addr_q      <= Addr;
            storeData_q <= StoreData;
         end
         if (state_q == ST_RMW_RD) word_q <= MemReadData;
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic misaligned_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) misaligned_q <= 1'b0;
      else       misaligned_q <= (state_q == ST_TRAP);
   end

   assign Misaligned = misaligned_q;
`else
   assign Misaligned = 1'b0;
`endif

   lane_align u_laneAlign (
      .op_i         (op_q),
      .offset_i     (addr_q[1:0]),
      .loadWord_i   (MemReadData),
      .mergeWord_i  (word_q),
      .storeData_i  (storeData_q),
      .loadResult_o (loadResult),
      .mergedWord_o (mergedWord)
   );

   // Strobes decode straight from state so an async reset drops them immediately
   always_comb begin
      MemWriteData = '0;
      if (state_q == ST_STORE)  MemWriteData = storeData_q;
      if (state_q == ST_RMW_WR) MemWriteData = mergedWord;
   end

   assign MemRead    = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
   assign MemWrite   = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
   assign MemAddress = {addr_q[ADDR_W-1:2], 2'b00};
   assign Ready      = (state_q == ST_IDLE);
   assign Done       = done_q;
   assign LoadData   = loadData_q;

endmodule
